custom_simd_dispatch: RTL

//  Issue/write-back scheduler for the custom SIMD units (sorter, merger, prefix sum, C3 template).

---
 rtl/custom_simd_dispatch_pkg.sv | 47 ++++
 rtl/custom_simd_dispatch_if.sv | 38 +++
 rtl/custom_simd_dispatch_wb_reservation_sr.sv | 43 ++++
 rtl/custom_simd_dispatch.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/custom_simd_dispatch_pkg.sv
// Shared types and constants for the custom SIMD issue/write-back dispatcher.
// Holds the op encodings, default unit latencies and the write-back entry layout.
// Also holds small constant helpers used by the dispatcher and its shift register.
package custom_simd_dispatch_pkg;

  localparam int OP_W   = 2;
  localparam int VREG_W = 3;
  localparam int NVREG  = 8;
  localparam int RD_W   = 5;

  typedef enum logic [OP_W-1:0] {
    OP_SORT  = 2'd0,
    OP_MERGE = 2'd1,
    OP_PSUM  = 2'd2,
    OP_C3    = 2'd3
  } op_e;

  // Default issue->out_v latencies of each unit.
  localparam int LAT_SORT_DEF  = 6;
  localparam int LAT_MERGE_DEF = 5;
  localparam int LAT_PSUM_DEF  = 4;
  localparam int LAT_C3_DEF    = 5;

  // One reserved write-back slot.
  typedef struct packed {
    logic              v;
    op_e               unit;
    logic [VREG_W-1:0] vrd1;
    logic [VREG_W-1:0] vrd2;
    logic              two;
  } wb_entry_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // MERGE and C3 produce two destination vregs.
  function automatic logic uses_two(input op_e op);
    return (op == OP_MERGE) || (op == OP_C3);
  endfunction

endpackage

// File: rtl/custom_simd_dispatch_if.sv
// Interface bundling decode-side issue signals, unit start pulses and VRF write-back.
// master: core decode / unit side (drives issue_*, merge_not_accepting).
// slave : dispatcher (drives issue_ready, <unit>_in_v, wb_*).
interface custom_simd_dispatch_if;
  import custom_simd_dispatch_pkg::*;

  logic              issue_v;
  logic              issue_ready;
  logic [OP_W-1:0]   issue_op;
  logic [RD_W-1:0]   issue_rd;
  logic [VREG_W-1:0] issue_vrd1;
  logic [VREG_W-1:0] issue_vrd2;

  logic              sort_in_v;
  logic              merge_in_v;
  logic              psum_in_v;
  logic              c3_in_v;
  logic              merge_not_accepting;

  logic              wb_v;
  logic [OP_W-1:0]   wb_unit;
  logic [VREG_W-1:0] wb_vrd1;
  logic [VREG_W-1:0] wb_vrd2;
  logic              wb_two;

  modport master (
    output issue_v, issue_op, issue_rd, issue_vrd1, issue_vrd2, merge_not_accepting,
    input  issue_ready, sort_in_v, merge_in_v, psum_in_v, c3_in_v,
    input  wb_v, wb_unit, wb_vrd1, wb_vrd2, wb_two
  );

  modport slave (
    input  issue_v, issue_op, issue_rd, issue_vrd1, issue_vrd2, merge_not_accepting,
    output issue_ready, sort_in_v, merge_in_v, psum_in_v, c3_in_v,
    output wb_v, wb_unit, wb_vrd1, wb_vrd2, wb_two
  );

endinterface

// File: rtl/custom_simd_dispatch_wb_reservation_sr.sv
// Write-back reservation table: DEPTH-deep shift register of wb entries, shifting toward slot 0.
// Ports: clk, reset (async, active-high); i_wr_en/i_wr_idx/i_wr_entry write one slot (post-shift index);
//        o_slot_v = valid bit of every slot; o_head = slot 0, the entry owning the VRF port this cycle.
module wb_reservation_sr
  import custom_simd_dispatch_pkg::*;
#(
  parameter int DEPTH = 6,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [IW-1:0]    i_wr_idx,
  input  wb_entry_t        i_wr_entry,
  output logic [DEPTH-1:0] o_slot_v,
  output wb_entry_t        o_head
);

  wb_entry_t r_tab [DEPTH];

  // The write index addresses the table after this cycle's shift, so an entry
  // written at index k reaches the head k+1 cycles later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_tab[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i_wr_en && (i_wr_idx == IW'(i))) r_tab[i] <= i_wr_entry;
        else                                 r_tab[i] <= r_tab[i+1];
      end
      if (i_wr_en && (i_wr_idx == IW'(DEPTH - 1))) r_tab[DEPTH-1] <= i_wr_entry;
      else                                        r_tab[DEPTH-1] <= '0;
    end
  end

  always_comb begin
    o_slot_v = '0;
    for (int i = 0; i < DEPTH; i++) o_slot_v[i] = r_tab[i].v;
  end

  assign o_head = r_tab[0];

endmodule

// File: rtl/custom_simd_dispatch.sv
// Issue/write-back scheduler for the custom SIMD units (sorter, merger, prefix sum, C3).
// Ports: clk, reset (async, active-high), dsp (slave modport: issue handshake, unit in_v pulses, VRF wb);
//        with CUSTOM_SIMD_DISPATCH_PERF_EN defined also stall_cnt[31:0] and issue_cnt[31:0].
module custom_simd_dispatch
  import custom_simd_dispatch_pkg::*;
#(
  parameter int LAT_SORT  = LAT_SORT_DEF,
  parameter int LAT_MERGE = LAT_MERGE_DEF,
  parameter int LAT_PSUM  = LAT_PSUM_DEF,
  parameter int LAT_C3    = LAT_C3_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  custom_simd_dispatch_if.slave  dsp
`ifdef CUSTOM_SIMD_DISPATCH_PERF_EN
  ,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            issue_cnt
`endif
);

  localparam int MAXLAT = max4(LAT_SORT, LAT_MERGE, LAT_PSUM, LAT_C3);
  localparam int LW     = $clog2(MAXLAT + 1);
  localparam int SW     = $clog2(MAXLAT);

  op_e              w_op;
  logic             w_two;
  logic [LW-1:0]    w_lat;
  logic [MAXLAT-1:0] w_slot_v;
  logic [MAXLAT:0]  w_slot_ext;
  logic             w_slot_conflict;
  logic             w_hazard;
  logic             w_merge_block;
  logic             w_ready;
  logic             w_accept;
  wb_entry_t        w_wr_entry;
  wb_entry_t        w_head;
  logic [NVREG-1:0] w_sb_set;
  logic [NVREG-1:0] w_sb_clr;
  logic             w_unused_rd;

  logic [NVREG-1:0] r_sb;
  logic             r_merge_inflight;

  // Scalar rd travels with the op to the unit; the dispatcher never tracks it.
  assign w_unused_rd = ^dsp.issue_rd;

  assign w_op  = op_e'(dsp.issue_op);
  assign w_two = uses_two(w_op);

  always_comb begin
    w_lat = LW'(LAT_SORT);
    case (w_op)
      OP_SORT:  w_lat = LW'(LAT_SORT);
      OP_MERGE: w_lat = LW'(LAT_MERGE);
      OP_PSUM:  w_lat = LW'(LAT_PSUM);
      OP_C3:    w_lat = LW'(LAT_C3);
      default:  w_lat = LW'(LAT_SORT);
    endcase
  end

  // Slot k (pre-shift) is the entry that owns the VRF port k cycles from now;
  // slot MAXLAT is never occupied, hence the constant-zero extension bit.
  assign w_slot_ext      = {1'b0, w_slot_v};
  assign w_slot_conflict = w_slot_ext[w_lat];

  // No bypass: a dest clears only in the cycle after its write-back.
  assign w_hazard      = r_sb[dsp.issue_vrd1] | (w_two & r_sb[dsp.issue_vrd2]);
  assign w_merge_block = (w_op == OP_MERGE) && (r_merge_inflight || dsp.merge_not_accepting);

  assign w_ready  = !reset && !w_slot_conflict && !w_hazard && !w_merge_block;
  assign w_accept = dsp.issue_v && w_ready;

  assign dsp.issue_ready = w_ready;
  assign dsp.sort_in_v   = w_accept && (w_op == OP_SORT);
  assign dsp.merge_in_v  = w_accept && (w_op == OP_MERGE);
  assign dsp.psum_in_v   = w_accept && (w_op == OP_PSUM);
  assign dsp.c3_in_v     = w_accept && (w_op == OP_C3);

  always_comb begin
    w_wr_entry      = '0;
    w_wr_entry.v    = 1'b1;
    w_wr_entry.unit = w_op;
    w_wr_entry.vrd1 = dsp.issue_vrd1;
    w_wr_entry.vrd2 = w_two ? dsp.issue_vrd2 : '0;
    w_wr_entry.two  = w_two;
  end

  wb_reservation_sr #(
    .DEPTH (MAXLAT),
    .IW    (SW)
  ) u_wb_sr (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (w_accept),
    .i_wr_idx   (SW'(w_lat - LW'(1))),
    .i_wr_entry (w_wr_entry),
    .o_slot_v   (w_slot_v),
    .o_head     (w_head)
  );

  assign dsp.wb_v    = w_head.v;
  assign dsp.wb_unit = w_head.unit;
  assign dsp.wb_vrd1 = w_head.vrd1;
  assign dsp.wb_vrd2 = w_head.vrd2;
  assign dsp.wb_two  = w_head.two;

  always_comb begin
    w_sb_set = '0;
    if (w_accept) begin
      w_sb_set[dsp.issue_vrd1] = 1'b1;
      if (w_two) w_sb_set[dsp.issue_vrd2] = 1'b1;
    end
  end

  always_comb begin
    w_sb_clr = '0;
    if (w_head.v) begin
      w_sb_clr[w_head.vrd1] = 1'b1;
      if (w_head.two) w_sb_clr[w_head.vrd2] = 1'b1;
    end
  end

  // Set and clear of different vregs in one cycle both land; the hazard check
  // guarantees the same vreg is never set while its clear is pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sb <= '0;
    else       r_sb <= (r_sb & ~w_sb_clr) | w_sb_set;
  end

  // Only one MERGE can be in flight, so its issue and retirement never coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        r_merge_inflight <= 1'b0;
    else if (w_accept && (w_op == OP_MERGE))          r_merge_inflight <= 1'b1;
    else if (w_head.v && (w_head.unit == OP_MERGE))   r_merge_inflight <= 1'b0;
  end

`ifdef CUSTOM_SIMD_DISPATCH_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_issue_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_issue_cnt <= '0;
    end else begin
      if (dsp.issue_v && !w_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_accept)                r_issue_cnt <= r_issue_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign issue_cnt = r_issue_cnt;
`endif

endmodule
